// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I instruction fetch. Owns the PC, addresses the
// combinational instruction memory, and queues {pc, inst} pairs in a small
// FIFO that decode drains via valid/ready. Redirects flush and restart.
// Optional feature macro: IF_MISALIGN_TRAP_EN (trap on misaligned redirect).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        misalign_err
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc;
    logic [31:0]   redirect_tgt;
    logic          halted;
    logic          push, pop;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q;
    logic redirect_misaligned;

    assign redirect_misaligned = |redirect_pc[1:0];
    // A misaligned target is kept verbatim so the trap handler sees it.
    assign redirect_tgt = redirect_misaligned ? redirect_pc
                                              : {redirect_pc[31:2], 2'b00};

    // Sticky trap flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (redirect_valid)
            misalign_q <= redirect_misaligned;
    end

    assign halted       = misalign_q;
    assign misalign_err = misalign_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign halted              = 1'b0;
    assign misalign_err        = 1'b0;
`endif

    // Redirect blanks the head so decode never consumes a wrong-path entry.
    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push      = fetch_en & ~redirect_valid & ~halted & ((count < FULL) | pop);

    assign imem_addr = pc;
    assign out_pc    = mem[rd_ptr].pc;
    assign out_inst  = mem[rd_ptr].inst;

    // Program counter: redirect wins, otherwise advance one word per push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= redirect_tgt;
        else if (push)
            pc <= pc + 32'd4;
    end

    // FIFO storage, pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pc, imem_inst};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage for the RV32I core. Owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction word with its PC into a small FIFO. Decode drains the FIFO through a valid/ready handshake. Branch and jump redirects flush the FIFO and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- DEPTH, 2: FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fetch_en  in  1  fetch permitted this cycle; 0 holds the PC and blocks pushes.
- imem_addr  out  32  byte address to the instruction memory; always equal to the PC register.
- imem_inst  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  redirect request from the execute stage.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of the instruction at the FIFO head.
- misalign_err  out  1  misaligned-redirect flag. Tied to 0 unless IF_MISALIGN_TRAP_EN is defined.

## Operation
- State consists of:
  - pc (32 bits);
  - FIFO storage: DEPTH entries of {pc, inst};
  - write pointer, read pointer, and count (0..DEPTH);
  - misalign_err.
- pop = out_valid & out_ready.
- push = fetch_en & !redirect_valid & !halted & (count < DEPTH | pop).
  - halted is asserted only under IF_MISALIGN_TRAP_EN.
- On push:
  - write {pc, imem_inst} at the write pointer;
  - pc <= pc + 4, which wraps modulo 2^32 (32'hFFFF_FFFC goes to 0).
- On pop: advance the read pointer. Pointers wrap modulo DEPTH.
- count updates to count + push - pop.
  - Push and pop in the same cycle while full is legal; count stays DEPTH.
  - Push and pop in the same cycle while count is 1 is legal; count stays 1.
- out_valid = (count != 0) & !redirect_valid.
- out_inst and out_pc present the FIFO head whenever out_valid is 1. Their values while out_valid is 0 are don't-care.
- Redirect has priority over push and pop. In a cycle with redirect_valid = 1:
  - count <= 0 and both pointers <= 0;
  - pc <= {redirect_pc[31:2], 2'b00};
  - no push and no pop occur, and out_valid is 0.
- fetch_en = 0 freezes pc and stops pushes. Pops continue.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, count = 0, out_valid = 0, out_inst = 0, out_pc = 0 (storage is cleared), misalign_err = 0.
- Reset asserted mid-operation discards all FIFO contents immediately.
- Latency:
  - From fetch to out_valid: 1 cycle. An instruction pushed at edge N is visible at the head after edge N.
  - There is no bypass from imem_inst to out_inst.
  - From redirect to the first target instruction at the head: 1 cycle after the redirect cycle. The target is pushed in the cycle following the redirect and appears after the next edge.
- Throughput: 1 instruction per cycle sustained while out_ready = 1.
- With out_ready held at 0, at most DEPTH instructions are fetched; pc then holds at RESET_PC + 4·DEPTH.

## Configuration
- IF_MISALIGN_TRAP_EN, defined:
  - A redirect with redirect_pc[1:0] != 0 loads pc with the unmodified redirect_pc and sets misalign_err (sticky) and halted.
  - While halted, no pushes occur.
  - Both misalign_err and halted clear on the next aligned redirect or on reset.
- IF_MISALIGN_TRAP_EN, undefined:
  - redirect_pc[1:0] is ignored (forced to 0).
  - misalign_err is constant 0 and no halted state exists.

## Test plan
- Reset, RESET_PC = 0, fetch_en = 1, out_ready = 1 → out_valid rises after the first edge; out_pc sequence 0, 4, 8, 12; out_inst matches memory words 0..3.
- out_ready = 0 for 5 cycles, DEPTH = 2 → count saturates at 2; imem_addr holds at 8. Release → out_pc 0, 4, 8 in consecutive cycles.
- Redirect to 32'h40 while the FIFO is full → out_valid = 0 in the redirect cycle; the next head is out_pc = 32'h40; entries 0 and 4 are never delivered.
- Start at pc = 32'hFFFF_FFF8 via redirect → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 32'h42:
  - macro on → misalign_err = 1, no further out_valid; a later redirect to 32'h80 clears it and fetch resumes at 32'h80.
  - macro off → fetch resumes at 32'h40.
- Assert rst asynchronously mid-stream with count = 2 → out_valid drops immediately; pc = RESET_PC.
